// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on both sides.
//
// It keeps the 4-bit opcode map of the older combinational ALU:
//   0 NAND, 1 NOR, 2 XNOR, 3 GT, 4 LT, 5 EQ, 6 ADD, 7 SUB, 8 MUL, 9 DIV,
//   10..15 illegal.
// Bitwise, compare, ADD and SUB ops finish on the accept edge. DIV by zero
// and illegal ops also finish there. MUL uses a shift-add unit and DIV uses
// a restoring divider. Each of those takes WIDTH iterations, one per cycle.
//
// Ports
//   clk, rst_n           rising-edge clock, async active-low reset
//   in_valid / in_ready  input handshake; op, a and b are captured on accept
//   op, a, b             opcode and unsigned WIDTH-bit operands
//   out_valid/out_ready  output handshake; outputs hold while stalled
//   result               2*WIDTH-bit result
//   gt, lt, eq           unsigned compare of the captured a vs b
//   ovf                  ADD carry-out / SUB borrow
//   dz                   DIV with b == 0
//   err                  illegal opcode
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               gt,
  output logic               lt,
  output logic               eq,
  output logic               ovf,
  output logic               dz,
  output logic               err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t             state_reg;
  logic [2*WIDTH-1:0] work_reg;
  logic [2*WIDTH-1:0] work_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic               is_div_reg;
  logic [CW-1:0]      cnt_reg;

  logic [2*WIDTH-1:0] quick_result;
  logic               quick_ovf;
  logic               quick_dz;
  logic               quick_err;
  logic               start_long;
  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     div_diff;

  // When a result is waiting, a new op can be taken on the same edge that
  // the consumer takes that result.
  assign in_ready = rst_n & ((state_reg == IDLE) | ((state_reg == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // A divide by zero never enters the iterative unit. It completes at once
  // with the fixed quotient and remainder.
  assign start_long = (op == 4'd8) | ((op == 4'd9) & (b != '0));

  // Results for the ops that finish on the accept edge.
  always_comb begin
    quick_result = '0;
    quick_ovf    = 1'b0;
    quick_dz     = 1'b0;
    quick_err    = 1'b0;
    case (op)
      4'd0: quick_result[WIDTH-1:0] = ~(a & b);
      4'd1: quick_result[WIDTH-1:0] = ~(a | b);
      4'd2: quick_result[WIDTH-1:0] = ~(a ^ b);
      4'd3, 4'd4, 4'd5: quick_result[2:0] = {a > b, a == b, a < b};
      4'd6: begin
        quick_result[WIDTH:0] = {1'b0, a} + {1'b0, b};
        quick_ovf             = quick_result[WIDTH];
      end
      4'd7: begin
        quick_result[WIDTH-1:0] = a - b;
        quick_ovf               = (a < b);
      end
      4'd8: quick_result = '0;
      4'd9: begin
        quick_result = {a, {WIDTH{1'b1}}};
        quick_dz     = 1'b1;
      end
      default: quick_err = 1'b1;
    endcase
  end

  // One iteration of the shared datapath.
  // MUL: work holds {partial product, remaining multiplier bits}. The
  //      multiplicand (opnd) is added into the top half, then work shifts
  //      right by one bit.
  // DIV: work holds {remainder, dividend/quotient}. The top bit of the
  //      dividend shifts into the remainder. If the trial subtract does not
  //      borrow, the remainder is updated and a 1 enters the quotient.
  always_comb begin
    mul_sum   = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
    rem_shift = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
    div_diff  = rem_shift - {1'b0, opnd_reg};
    if (is_div_reg) begin
      if (div_diff[WIDTH])
        work_next = {work_reg[2*WIDTH-2:0], 1'b0};
      else
        work_next = {div_diff[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};
    end else begin
      if (work_reg[0])
        work_next = {mul_sum, work_reg[WIDTH-1:1]};
      else
        work_next = {1'b0, work_reg[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      work_reg   <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
      cnt_reg    <= '0;
      out_valid  <= 1'b0;
      result     <= '0;
      gt         <= 1'b0;
      lt         <= 1'b0;
      eq         <= 1'b0;
      ovf        <= 1'b0;
      dz         <= 1'b0;
      err        <= 1'b0;
    end else if (state_reg == EXEC) begin
      work_reg <= work_next;
      cnt_reg  <= cnt_reg + CW'(1);
      if (cnt_reg == LAST) begin
        result    <= work_next;
        out_valid <= 1'b1;
        state_reg <= DONE;
      end
    end else if (accept) begin
      gt <= (a > b);
      lt <= (a < b);
      eq <= (a == b);
      if (start_long) begin
        // op[0] tells DIV (9) apart from MUL (8).
        is_div_reg <= op[0];
        opnd_reg   <= op[0] ? b : a;
        work_reg   <= op[0] ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
        cnt_reg    <= '0;
        out_valid  <= 1'b0;
        ovf        <= 1'b0;
        dz         <= 1'b0;
        err        <= 1'b0;
        state_reg  <= EXEC;
      end else begin
        result    <= quick_result;
        ovf       <= quick_ovf;
        dz        <= quick_dz;
        err       <= quick_err;
        out_valid <= 1'b1;
        state_reg <= DONE;
      end
    end else if ((state_reg == DONE) && out_ready) begin
      out_valid <= 1'b0;
      state_reg <= IDLE;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu with WIDTH=8.
// Each issued op pushes its expected output onto a queue. That entry is
// popped and compared when the DUT raises out_valid.
module tb_seq_alu;

  typedef struct packed {
    logic [15:0] res;
    logic [5:0]  flags;   // {gt, lt, eq, ovf, dz, err}
    logic [7:0]  lat;     // clocks from the accept edge until out_valid is seen
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        gt;
  logic        lt;
  logic        eq;
  logic        ovf;
  logic        dz;
  logic        err;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  seq_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq),
    .ovf       (ovf),
    .dz        (dz),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. It uses the arithmetic operators directly.
  function automatic exp_t model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic g, l, q, ov, d, er;
    logic [8:0] s;
    e.res = 16'h0000;
    e.lat = 8'd0;
    g = (x > y);
    l = (x < y);
    q = (x == y);
    ov = 1'b0;
    d = 1'b0;
    er = 1'b0;
    s = 9'd0;
    case (o)
      4'd0: e.res = {8'h00, ~(x & y)};
      4'd1: e.res = {8'h00, ~(x | y)};
      4'd2: e.res = {8'h00, ~(x ^ y)};
      4'd3, 4'd4, 4'd5: e.res = {13'd0, g, q, l};
      4'd6: begin s = {1'b0, x} + {1'b0, y}; e.res = {7'd0, s}; ov = s[8]; end
      4'd7: begin e.res = {8'h00, 8'(x - y)}; ov = l; end
      4'd8: begin e.res = 16'(x) * 16'(y); e.lat = 8'd8; end
      4'd9: begin
        if (y == 8'd0) begin
          e.res = {x, 8'hFF};
          d = 1'b1;
        end else begin
          e.res = {8'(x % y), 8'(x / y)};
          e.lat = 8'd8;
        end
      end
      default: er = 1'b1;
    endcase
    e.flags = {g, l, q, ov, d, er};
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Present an op and wait (bounded) until it is accepted. On return the
  // time is 1 unit after the accept edge, and op/a/b hold random values.
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    #1;
    while (in_ready !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb.push_back(model(o, x, y));
    #1;
    in_valid = 1'b0;
    op = 4'($urandom);
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  // Wait (bounded) for out_valid, then compare with the oldest expectation.
  task automatic wait_result(output exp_t e, input string tag);
    int n;
    bit busy_ok;
    n = 0;
    busy_ok = 1'b1;
    e = '0;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    while (out_valid !== 1'b1 && n < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(e.lat));
    if (e.lat != 8'd0) chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, "_res"}, 32'(result), 32'(e.res));
    chk({tag, "_flags"}, 32'({gt, lt, eq, ovf, dz, err}), 32'(e.flags));
    $display("[%0t] %s result=%04h gt/lt/eq/ovf/dz/err=%06b lat=%0d", $time, tag, result,
             {gt, lt, eq, ovf, dz, err}, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    bit seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; a = 8'd0; b = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({gt, lt, eq, ovf, dz, err}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(in_ready), 32'd1);

    // Main ops, with out_ready held high (back-to-back issue)
    out_ready = 1'b1;
    send(4'd6, 8'hFF, 8'h01); wait_result(e, "add");
    send(4'd7, 8'h05, 8'h09); wait_result(e, "sub");
    send(4'd8, 8'd200, 8'd150); wait_result(e, "mul");
    send(4'd9, 8'd200, 8'd7);   wait_result(e, "div");
    send(4'd9, 8'h33, 8'h00);   wait_result(e, "div0");
    send(4'd0, 8'hF0, 8'h3C);   wait_result(e, "nand");
    send(4'd1, 8'hF0, 8'h3C);   wait_result(e, "nor");
    send(4'd3, 8'h10, 8'h20);   wait_result(e, "gt_op");
    send(4'd9, 8'hFF, 8'h01);   wait_result(e, "div_by1");
    send(4'd8, 8'hFF, 8'hFF);   wait_result(e, "mul_max");
    for (int i = 0; i < 6; i++) begin
      send(4'($urandom_range(0, 9)), 8'($urandom), 8'($urandom));
      wait_result(e, "rand");
    end
    @(posedge clk); #1;
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Hold XNOR while the consumer stalls, then consume and accept EQ on one edge
    out_ready = 1'b0;
    send(4'd2, 8'hA5, 8'h3C); wait_result(e, "xnor");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_result", 32'(result), 32'h0066);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    op = 4'd5; a = 8'h10; b = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("eq_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb.push_back(model(4'd5, 8'h10, 8'h10));
    #1;
    in_valid = 1'b0;
    chk("eq_valid_kept", 32'(out_valid), 32'd1);
    wait_result(e, "eq");
    @(posedge clk); #1;
    chk("drop_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a MUL
    send(4'd8, 8'd13, 8'd11);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_flags", 32'({gt, lt, eq, ovf, dz, err}), 32'd0);
    chk("mrst_ready", 32'(in_ready), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("mrst_release_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("no_stale", 32'(seen), 32'd0);

    // Illegal opcode
    send(4'hC, 8'h12, 8'h34); wait_result(e, "illegal");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
